// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared encodings and screen limits for the pacman move sequencer
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MOVING  = 2'b01,
    ST_STOPPED = 2'b10
  } state_t;

  localparam int X_MAX_DEFAULT = 639;
  localparam int Y_MAX_DEFAULT = 479;

  // Fixed button priority; right wins only when nothing else is pressed.
  function automatic dir_t pick_dir(input logic b_up, input logic b_down, input logic b_left);
    if (b_up)        return DIR_UP;
    else if (b_down) return DIR_DOWN;
    else if (b_left) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/pacman_tick_gen.sv
// rtl/pacman_tick_gen.sv - free-running movement tick divider
module pacman_tick_gen #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int            CW   = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/pacman_move_sequencer.sv
// rtl/pacman_move_sequencer.sv - button-driven sprite movement sequencer with maze legality
module pacman_move_sequencer
  import pacman_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int X_MAX    = X_MAX_DEFAULT,
  parameter int Y_MAX    = Y_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       leg_u,
  input  logic       leg_d,
  input  logic       leg_l,
  input  logic       leg_r,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] cur_dir,
  output logic       step,
  output logic       blocked
);

  localparam logic [9:0] X_LIM = 10'(X_MAX);
  localparam logic [9:0] Y_LIM = 10'(Y_MAX);

  logic       w_tick;
  logic       w_btn_any;
  dir_t       w_btn_dir;
  logic [3:0] w_legs;
  logic       w_adopt;
  dir_t       w_move_dir;
  logic       w_try_move;
  logic       w_legal;
  logic [9:0] w_next_x;
  logic [9:0] w_next_y;

  state_t     r_state;
  dir_t       r_cur_dir;
  dir_t       r_pend_dir;
  logic       r_pend_valid;
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;
  logic       r_step;
  logic       r_blocked;

  pacman_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  always_comb begin
    w_btn_any  = up | down | left | right;
    w_btn_dir  = pick_dir(up, down, left);
    w_legs     = {leg_r, leg_l, leg_d, leg_u};
    w_adopt    = r_pend_valid && w_legs[r_pend_dir];
    w_move_dir = w_adopt ? r_pend_dir : r_cur_dir;
    // IDLE only starts moving once a request has actually been adopted.
    w_try_move = w_adopt || (r_state != ST_IDLE);
    w_legal    = 1'b0;
    w_next_x   = r_pos_x;
    w_next_y   = r_pos_y;
    case (w_move_dir)
      DIR_UP: begin
        w_legal  = leg_u && (r_pos_y != 10'd0);
        w_next_y = r_pos_y - 10'd1;
      end
      DIR_DOWN: begin
        w_legal  = leg_d && (r_pos_y < Y_LIM);
        w_next_y = r_pos_y + 10'd1;
      end
      DIR_LEFT: begin
        w_legal  = leg_l;
        w_next_x = (r_pos_x == 10'd0) ? X_LIM : r_pos_x - 10'd1;
      end
      DIR_RIGHT: begin
        w_legal  = leg_r;
        w_next_x = (r_pos_x >= X_LIM) ? 10'd0 : r_pos_x + 10'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur_dir    <= DIR_RIGHT;
      r_pend_dir   <= DIR_UP;
      r_pend_valid <= 1'b0;
      r_pos_x      <= 10'(X_INIT);
      r_pos_y      <= 10'(Y_INIT);
      r_step       <= 1'b0;
      r_blocked    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_tick) begin
        if (w_adopt) begin
          r_cur_dir    <= r_pend_dir;
          r_pend_valid <= 1'b0;
        end
        if (w_try_move) begin
          if (w_legal) begin
            r_pos_x   <= w_next_x;
            r_pos_y   <= w_next_y;
            r_step    <= 1'b1;
            r_state   <= ST_MOVING;
            r_blocked <= 1'b0;
          end else begin
            r_state   <= ST_STOPPED;
            r_blocked <= 1'b1;
          end
        end
      end
      // A press on the tick edge overrides the clear above and waits for the next tick.
      if (w_btn_any) begin
        r_pend_dir   <= w_btn_dir;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign cur_dir = r_cur_dir;
  assign step    = r_step;
  assign blocked = r_blocked;

endmodule

// File: doc/pacman_move_sequencer.md
PACMAN_MOVE_SEQUENCER -- requirements
Module: pacman_move_sequencer

Interface
REQ-001 Parameters:
- STEP_DIV, default 4: clock cycles per movement tick, minimum 2.
- X_INIT, default 320: reset x position.
- Y_INIT, default 240: reset y position.
- X_MAX, default 639: rightmost x.
- Y_MAX, default 479: bottom y.
REQ-002 Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- up, down, left, right  in  1 each  debounced button levels.
- leg_u, leg_d, leg_l, leg_r  in  1 each  maze-legal flags for a move from the current position, valid every cycle.
- pos_x  out  10  sprite x.
- pos_y  out  10  sprite y.
- cur_dir  out  2  active direction.
- step  out  1  one-cycle pulse on each position update.
- blocked  out  1  high while in STOPPED.

Function
REQ-003 Direction encoding SHALL be up=00, down=01, left=10, right=11.
REQ-004 Button priority SHALL be up > down > left > right when several are high in the same cycle.
REQ-005 On any edge with a button high, pending_dir SHALL latch the winning direction and pend_valid SHALL set; a later press SHALL overwrite it.
REQ-006 The tick counter SHALL count 0..STEP_DIV-1 and wrap; tick is high when count equals STEP_DIV-1.
REQ-007 The FSM SHALL have three states: IDLE, MOVING and STOPPED.
REQ-008 Action on a tick, in this order:
- (a) If pend_valid and leg of pending_dir is 1: cur_dir<=pending_dir and pend_valid clears.
- (b) The move is evaluated with the direction selected in (a) and the leg_* values of that same cycle.
REQ-009 Move legal: pos updates at that clock edge, step=1 the following cycle with the new pos, state<=MOVING.
REQ-010 Move illegal: pos is held, state<=STOPPED, and the pending request is retained.
REQ-011 In IDLE, no movement SHALL occur until a pending direction is adopted.
REQ-012 In STOPPED, ticks SHALL continue; a move SHALL resume when either the pending or the current direction becomes legal.
REQ-013 Arithmetic is 10-bit.
- right at X_MAX wraps pos_x to 0.
- left at 0 wraps pos_x to X_MAX.
REQ-014 Vertical moves SHALL NOT wrap. up at y=0 or down at Y_MAX is treated as illegal regardless of leg_*.
REQ-015 Buttons SHALL NOT cause movement between ticks; only pending_dir changes.
REQ-016 A button press on a tick cycle SHALL be latched, and adopted no earlier than the next tick.

Reset
REQ-017 Asserting rst low SHALL immediately set:
- pos_x=X_INIT, pos_y=Y_INIT
- cur_dir=11, pend_valid=0, pending_dir=00
- tick count=0, step=0, blocked=0
- state=IDLE
REQ-018 Reset asserted mid-move SHALL discard any in-flight update.
REQ-019 The first tick SHALL occur STEP_DIV cycles after rst deasserts.

Structure
REQ-020 Package pacman_pkg SHALL hold:
- direction encoding constants
- state encoding
- the default screen limits 639/479
REQ-021 The tick divider SHALL be a sub-module, pacman_tick_gen, with the same clk/rst and a STEP_DIV parameter.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (STEP_DIV=4)
REQ-023 Reset, hold right, leg_r=1 -> first step pulse 4 cycles after release, pos_x=321; after 10 ticks pos_x=330, pos_y=240.
REQ-024 X_INIT=639, right held, leg_r=1 -> after one tick pos_x=0; then left -> pos_x=639.
REQ-025 Moving right, leg_r drops to 0 -> next tick pos unchanged, blocked=1, state STOPPED; leg_r back to 1 -> following tick pos_x+1, blocked=0.
REQ-026 Moving right, pulse up for 1 cycle with leg_u=0 for 2 ticks, then leg_u=1 -> right steps continue for 2 ticks; third tick cur_dir=00, pos_y=239.
REQ-027 up and left asserted in the same cycle, all leg_*=1 -> cur_dir=00 and pos_y decrements. Y_INIT=0, up -> blocked=1.
REQ-028 rst low for 1 cycle while moving at pos_x=325 -> pos_x=320, state IDLE, step=0 immediately, no step until a button is pressed.
